// File: rtl/fetch_pkg.sv
// Shared constants for the fetch / decode front end.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          PC_STEP     = 4;
  localparam int          IMM_FIELD_W = 26;
endpackage

// File: rtl/pc_register.sv
// Fetch PC register: redirect beats stall, stall beats sequential increment.
module pc_register
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect,
  input  logic         stall,
  input  logic [N-1:0] target,
  output logic [N-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (!stall) begin
      pc <= pc + N'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Processor front end: fetch PC, synchronous instruction memory interface and the IF/ID register.
module fetch_decode_stage
  import fetch_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   StallF,
  input  logic                   StallD,
  input  logic                   FlushD,
  input  logic                   PCSrcE,
  input  logic [N-1:0]           BranchTargetE,
  output logic [N-1:0]           IMemAddr,
  input  logic [N-1:0]           IMemRdData,
  output logic [N-1:0]           InstrD,
  output logic [IMM_FIELD_W-1:0] ImmFieldD,
  output logic [N-1:0]           PCD,
  output logic [N-1:0]           PCPlus4D,
  output logic                   ValidD
);

  logic [N-1:0] pcF;
  logic [N-1:0] holdInstr;
  logic         holdValid;
  logic         stallFetch;
  logic         squashD;

  // A decode stall without a fetch stall is illegal; fetch is held anyway so no instruction is lost.
  assign stallFetch = StallF | StallD;
  assign squashD    = FlushD | PCSrcE;

  pc_register #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pcRegister (
    .clk      (clk),
    .rst      (rst),
    .redirect (PCSrcE),
    .stall    (stallFetch),
    .target   (BranchTargetE),
    .pc       (pcF)
  );

  assign IMemAddr = pcF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCD    <= '0;
      ValidD <= 1'b0;
    end else if (squashD) begin
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (StallF) begin
        ValidD <= 1'b0;
      end else begin
        PCD    <= pcF;
        ValidD <= 1'b1;
      end
    end
  end

  // Memory keeps reading the held PCF during a stall, so the decode word is captured once and replayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdValid <= 1'b0;
      holdInstr <= '0;
    end else if (squashD || !StallD) begin
      holdValid <= 1'b0;
    end else if (ValidD && !holdValid) begin
      holdValid <= 1'b1;
      holdInstr <= IMemRdData;
    end
  end

  always_comb begin
    InstrD = N'(NOP_INSTR);
    if (ValidD) begin
      InstrD = holdValid ? holdInstr : IMemRdData;
    end
  end

  assign ImmFieldD = InstrD[IMM_FIELD_W-1:0];
  assign PCPlus4D  = PCD + N'(PC_STEP);

  illegalStall: assert property (@(posedge clk) disable iff (!rst) !(StallD && !StallF));

endmodule
